// File: rtl/reglist_encoder_seq_if.sv
// rtl/reglist_encoder_seq_if.sv - request/beat bundle between control unit and reglist encoder
interface reglist_encoder_seq_if #(
  parameter int N_REGS = 16,
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 32
);
  logic              start;
  logic [N_REGS-1:0] reg_list;
  logic [ADDR_W-1:0] base_addr;
  logic              ready;
  logic              valid;
  logic [IDX_W-1:0]  reg_idx;
  logic [ADDR_W-1:0] mem_addr;
  logic              last;
  logic              busy;
  logic              done;
  logic [IDX_W:0]    count;

  modport master (
    output start, reg_list, base_addr, ready,
    input  valid, reg_idx, mem_addr, last, busy, done, count
  );

  modport slave (
    input  start, reg_list, base_addr, ready,
    output valid, reg_idx, mem_addr, last, busy, done, count
  );
endinterface

// File: rtl/reglist_encoder_seq.sv
// rtl/reglist_encoder_seq.sv - sequential 16-to-4 priority encoder for LDM/STM register lists
module reglist_encoder_seq #(
  parameter int N_REGS = 16,
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 32
) (
  input logic               clk,
  input logic               reset,
  reglist_encoder_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  state_e            state_q, state_d;
  logic [N_REGS-1:0] pending_q, pending_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IDX_W:0]    count_q, count_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [IDX_W-1:0]  low_idx;
  logic              single;
  logic [IDX_W:0]    list_pop;

  // Scan from the top so the lowest set bit is the one that sticks.
  always_comb begin
    low_idx = '0;
    for (int i = N_REGS - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    list_pop = '0;
    for (int i = 0; i < N_REGS; i++) begin
      list_pop = list_pop + (IDX_W + 1)'(bus.reg_list[i]);
    end
  end

  assign single = (pending_q != '0) &&
                  ((pending_q & (pending_q - N_REGS'(1))) == '0);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    addr_d    = addr_q;
    count_d   = count_q;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          pending_d = bus.reg_list;
          addr_d    = bus.base_addr;
          count_d   = list_pop;
          if (bus.reg_list == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      ISSUE: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        if (bus.ready) begin
          pending_d[low_idx] = 1'b0;
          addr_d = addr_q + ADDR_W'(4);
          if (single) begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Beat fields are forced to zero outside a beat so downstream never sees stale data.
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.count    = count_q;
  assign bus.reg_idx  = valid_q ? low_idx : '0;
  assign bus.mem_addr = valid_q ? addr_q : '0;
  assign bus.last     = valid_q & single;
endmodule

// File: tb/tb_reglist_encoder_seq.sv
// tb/tb_reglist_encoder_seq.sv - self-checking bench for reglist_encoder_seq
module tb_reglist_encoder_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reglist_encoder_seq_if bus ();
  reglist_encoder_seq dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] addr;
  } beat_t;

  beat_t      m_q[$];
  int         m_mode;
  logic [4:0] m_count;
  bit         m_ok;
  int         checks;
  int         failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: expand the accepted list into its beat sequence, then pop one per accepted beat.
  task automatic model_step();
    beat_t b;
    if (reset) begin
      m_q.delete();
      m_mode  = 0;
      m_count = '0;
      m_ok    = 1'b1;
    end else if (m_ok) begin
      case (m_mode)
        0: if (bus.start) begin
          m_count = 5'($countones(bus.reg_list));
          m_q.delete();
          for (int i = 0; i < 16; i++) begin
            if (bus.reg_list[i]) begin
              b.idx  = 4'(i);
              b.addr = bus.base_addr + 32'(4 * m_q.size());
              m_q.push_back(b);
            end
          end
          m_mode = (m_q.size() == 0) ? 2 : 1;
        end
        1: if (bus.ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_mode = 2;
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic model_check();
    logic        mv;
    logic [3:0]  ei;
    logic [31:0] ea;
    logic        el;
    if (!m_ok) return;
    mv = (m_mode == 1);
    ei = mv ? m_q[0].idx : 4'd0;
    ea = mv ? m_q[0].addr : 32'd0;
    el = mv && (m_q.size() == 1);
    chk("valid", 32'(bus.valid), 32'(mv));
    chk("busy", 32'(bus.busy), 32'(mv));
    chk("done", 32'(bus.done), 32'(m_mode == 2));
    chk("reg_idx", 32'(bus.reg_idx), 32'(ei));
    chk("mem_addr", bus.mem_addr, ea);
    chk("last", 32'(bus.last), 32'(el));
    chk("count", 32'(bus.count), 32'(m_count));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  task automatic cycn(input int n);
    repeat (n) cyc();
  endtask

  task automatic pin(input string tag, input logic v, input logic [3:0] i,
                     input logic [31:0] a, input logic l);
    chk({tag, "_valid"}, 32'(bus.valid), 32'(v));
    chk({tag, "_idx"}, 32'(bus.reg_idx), 32'(i));
    chk({tag, "_addr"}, bus.mem_addr, a);
    chk({tag, "_last"}, 32'(bus.last), 32'(l));
  endtask

  task automatic start_list(input logic [15:0] list, input logic [31:0] base);
    bus.start     = 1'b1;
    bus.reg_list  = list;
    bus.base_addr = base;
    cyc();
    bus.start = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    m_mode        = 0;
    m_count       = '0;
    m_ok          = 1'b0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.reg_list  = '0;
    bus.base_addr = '0;
    bus.ready     = 1'b0;
    cycn(2);
    pin("rst", 1'b0, 4'd0, 32'h0, 1'b0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_count", 32'(bus.count), 32'h0);
    reset = 1'b0;
    cyc();

    bus.ready = 1'b1;
    start_list(16'h8005, 32'h1000);
    pin("t1b0", 1'b1, 4'd0, 32'h1000, 1'b0);
    chk("t1_count", 32'(bus.count), 32'd3);
    cyc();
    pin("t1b1", 1'b1, 4'd2, 32'h1004, 1'b0);
    cyc();
    pin("t1b2", 1'b1, 4'd15, 32'h1008, 1'b1);
    cyc();
    chk("t1_done", 32'(bus.done), 32'd1);
    chk("t1_done_valid", 32'(bus.valid), 32'd0);
    cyc();
    chk("t1_done_once", 32'(bus.done), 32'd0);

    start_list(16'h0000, 32'h5000);
    chk("t2_done", 32'(bus.done), 32'd1);
    chk("t2_valid", 32'(bus.valid), 32'd0);
    chk("t2_count", 32'(bus.count), 32'd0);
    cyc();
    chk("t2_done_once", 32'(bus.done), 32'd0);
    start_list(16'h0001, 32'h0000_0010);
    pin("t2_next", 1'b1, 4'd0, 32'h10, 1'b1);
    cycn(2);

    start_list(16'hFFFF, 32'hFFFF_FFF8);
    pin("t3b0", 1'b1, 4'd0, 32'hFFFF_FFF8, 1'b0);
    chk("t3_count", 32'(bus.count), 32'd16);
    cyc();
    pin("t3b1", 1'b1, 4'd1, 32'hFFFF_FFFC, 1'b0);
    cyc();
    pin("t3b2", 1'b1, 4'd2, 32'h0, 1'b0);
    cycn(13);
    pin("t3b15", 1'b1, 4'd15, 32'h34, 1'b1);
    cyc();
    chk("t3_done", 32'(bus.done), 32'd1);
    cyc();

    bus.ready = 1'b0;
    start_list(16'h0012, 32'h200);
    pin("t4h0", 1'b1, 4'd1, 32'h200, 1'b0);
    cyc();
    pin("t4h1", 1'b1, 4'd1, 32'h200, 1'b0);
    cyc();
    pin("t4h2", 1'b1, 4'd1, 32'h200, 1'b0);
    cyc();
    pin("t4h3", 1'b1, 4'd1, 32'h200, 1'b0);
    bus.ready = 1'b1;
    cyc();
    pin("t4b1", 1'b1, 4'd4, 32'h204, 1'b1);
    cyc();
    chk("t4_done", 32'(bus.done), 32'd1);
    cyc();

    start_list(16'h0006, 32'h40);
    pin("t5b0", 1'b1, 4'd1, 32'h40, 1'b0);
    bus.start     = 1'b1;
    bus.reg_list  = 16'hFFFF;
    bus.base_addr = 32'h9000;
    cyc();
    pin("t5b1", 1'b1, 4'd2, 32'h44, 1'b1);
    cyc();
    chk("t5_done", 32'(bus.done), 32'd1);
    chk("t5_count", 32'(bus.count), 32'd2);
    cyc();
    chk("t5_idle_valid", 32'(bus.valid), 32'd0);
    bus.start    = 1'b0;
    bus.reg_list = '0;
    cyc();

    start_list(16'h00FF, 32'h80);
    pin("t6b0", 1'b1, 4'd0, 32'h80, 1'b0);
    cyc();
    pin("t6b1", 1'b1, 4'd1, 32'h84, 1'b0);
    reset = 1'b1;
    cyc();
    chk("t6_rst_valid", 32'(bus.valid), 32'd0);
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    chk("t6_rst_count", 32'(bus.count), 32'd0);
    reset = 1'b0;
    start_list(16'h00FF, 32'h300);
    pin("t6n0", 1'b1, 4'd0, 32'h300, 1'b0);
    chk("t6_count", 32'(bus.count), 32'd8);
    cycn(7);
    pin("t6n7", 1'b1, 4'd7, 32'h31C, 1'b1);
    cyc();
    chk("t6_done", 32'(bus.done), 32'd1);
    cycn(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
